// File: rtl/clkgen_frac.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clkgen_frac                                                  |
// | Description : Fractional clock-enable generator. A lock-qualified state    |
// |               machine gates NUM_CH phase accumulators whose carry-outs     |
// |               form one-cycle clock-enable pulses. Retunes while running    |
// |               are held pending and applied at the channel's next carry.    |
// |               Optional macro CLKGEN_PHASE_EN adds a per-channel phase      |
// |               preload register.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clkgen_frac #(
  parameter int          NUM_CH   = 2,
  parameter int          ACC_W    = 24,
  parameter int          LOCK_DLY = 16,
  parameter logic [31:0] INIT_INC = 32'd0
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              locked_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam int         c_cnt_w  = (LOCK_DLY > 1) ? $clog2(LOCK_DLY) : 1;
  localparam logic [3:0] c_num_ch = 4'(NUM_CH);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_SETTLE    = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_sync;
  logic               r_locked;
  logic               r_cfg_err;
  logic               w_lk_s;
  logic               w_run;
  logic               w_accept;
  logic               w_ch_bad;

  assign w_lk_s    = r_sync[1];
  // Accumulators only advance on edges that keep the machine in RUN.
  assign w_run     = r_locked && w_lk_s;
  assign cfg_ready = ~rst;
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_ch_bad  = {1'b0, cfg_ch} >= c_num_ch;
  assign cfg_err   = r_cfg_err;
  assign locked    = r_locked;

  // Two-flop synchroniser for the asynchronous PLL lock input.
  always_ff @(posedge refclk) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], locked_in};
  end

  // Lock state machine; locked is registered high exactly while in RUN.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state  <= S_WAIT_LOCK;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else begin
      r_locked <= 1'b0;
      case (r_state)
        S_WAIT_LOCK: begin
          if (w_lk_s) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
          end
        end
        S_SETTLE: begin
          if (!w_lk_s) begin
            r_state <= S_WAIT_LOCK;
          end else if (r_cnt == c_cnt_w'(LOCK_DLY - 1)) begin
            r_state  <= S_RUN;
            r_locked <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_RUN: begin
          if (!w_lk_s) r_state  <= S_WAIT_LOCK;
          else         r_locked <= 1'b1;
        end
        default: r_state <= S_WAIT_LOCK;
      endcase
    end
  end

  // Error pulse one cycle after a write addressed to a nonexistent channel.
  always_ff @(posedge refclk) begin
    if (rst) r_cfg_err <= 1'b0;
    else     r_cfg_err <= w_accept && w_ch_bad;
  end

`ifndef CLKGEN_PHASE_EN
  logic w_unused_phase;
  assign w_unused_phase = ^cfg_phase;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_pend_inc;
    logic             r_pend_vld;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_preload;
    logic             w_wr;

    assign w_wr  = w_accept && !w_ch_bad && (cfg_ch == 3'(gi));
    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign ce[gi] = r_ce;

`ifdef CLKGEN_PHASE_EN
    logic [ACC_W-1:0] r_phase;
    assign w_preload = r_phase;

    // Phase register captures the preload of every accepted write.
    always_ff @(posedge refclk) begin
      if (rst)       r_phase <= '0;
      else if (w_wr) r_phase <= cfg_phase;
    end
`else
    assign w_preload = '0;
`endif

    // Accumulate in RUN with carry-aligned retune; otherwise hold at preload.
    always_ff @(posedge refclk) begin
      if (rst) begin
        r_acc      <= '0;
        r_inc      <= INIT_INC[ACC_W-1:0];
        r_pend_inc <= '0;
        r_pend_vld <= 1'b0;
        r_ce       <= 1'b0;
      end else if (w_run) begin
        r_ce <= w_sum[ACC_W];
        // A zero increment never carries, so its retune cannot wait for one.
        if (r_pend_vld && (w_sum[ACC_W] || (r_inc == '0))) begin
          r_inc      <= r_pend_inc;
          r_acc      <= w_preload;
          r_pend_vld <= 1'b0;
        end else begin
          r_acc <= w_sum[ACC_W-1:0];
        end
        if (w_wr) begin
          r_pend_vld <= 1'b1;
          r_pend_inc <= cfg_inc;
        end
      end else begin
        r_ce  <= 1'b0;
        r_acc <= w_preload;
        if (w_wr) begin
          r_inc      <= cfg_inc;
          r_pend_vld <= 1'b0;
        end else if (r_pend_vld) begin
          r_inc      <= r_pend_inc;
          r_pend_vld <= 1'b0;
        end
      end
    end
  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_clkgen_frac.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clkgen_frac                                               |
// | Description : Self-checking bench for clkgen_frac with a lock-streak and   |
// |               arithmetic phase-accumulator reference model plus directed   |
// |               literal checks. Honours CLKGEN_PHASE_EN when defined.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clkgen_frac;

  localparam int     NUM_CH   = 2;
  localparam int     ACC_W    = 24;
  localparam int     LOCK_DLY = 4;
  localparam longint MODV     = 64'd1 << ACC_W;

  logic              refclk = 1'b0;
  logic              rst;
  logic              locked_in;
  logic              cfg_valid;
  logic [2:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_phase;
  wire               cfg_ready;
  wire               cfg_err;
  wire  [NUM_CH-1:0] ce;
  wire               locked;

  clkgen_frac #(
    .NUM_CH   (NUM_CH),
    .ACC_W    (ACC_W),
    .LOCK_DLY (LOCK_DLY),
    .INIT_INC (32'd0)
  ) u_dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked_in (locked_in),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .cfg_err   (cfg_err),
    .ce        (ce),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int tests  = 0;
  int fails  = 0;
  int edge_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Reference model: lock is a run of consecutive synchronised-high samples,
  // each channel is plain modular arithmetic on integers.
  bit          m_valid = 1'b0;
  bit          m_h0, m_h1, m_lks, m_run, m_locked, m_err;
  int          m_streak;
  bit [NUM_CH-1:0] m_ce;
  longint      m_acc [NUM_CH];
  longint      m_inc [NUM_CH];
  longint      m_pinc[NUM_CH];
  longint      m_ph  [NUM_CH];
  bit          m_pv  [NUM_CH];

  function automatic longint preload(input int ch);
`ifdef CLKGEN_PHASE_EN
    return m_ph[ch];
`else
    return 0;
`endif
  endfunction

  // Advance the model on every edge, then compare once outputs settle.
  always @(posedge refclk) begin
    edge_n++;
    if (rst) begin
      m_valid = 1'b1; m_h0 = 0; m_h1 = 0; m_streak = 0;
      m_locked = 0; m_err = 0; m_ce = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_acc[c] = 0; m_inc[c] = 0; m_pinc[c] = 0; m_ph[c] = 0; m_pv[c] = 0;
      end
    end else begin
      m_lks    = m_h1;
      m_run    = m_locked && m_lks;
      m_streak = m_lks ? ((m_streak < 100000) ? m_streak + 1 : m_streak) : 0;
      m_locked = (m_streak >= LOCK_DLY + 1);
      m_h1     = m_h0;
      m_h0     = locked_in;
      m_err    = cfg_valid && (int'(cfg_ch) >= NUM_CH);
      for (int c = 0; c < NUM_CH; c++) begin
        bit wr, carry;
        longint tot;
        wr = cfg_valid && (int'(cfg_ch) == c);
        if (m_run) begin
          tot   = m_acc[c] + m_inc[c];
          carry = (tot >= MODV);
          m_ce[c] = carry;
          if (m_pv[c] && (carry || m_inc[c] == 0)) begin
            m_inc[c] = m_pinc[c]; m_acc[c] = preload(c); m_pv[c] = 0;
          end else begin
            m_acc[c] = tot % MODV;
          end
          if (wr) begin m_pv[c] = 1; m_pinc[c] = longint'(cfg_inc); end
        end else begin
          m_ce[c]  = 0;
          m_acc[c] = preload(c);
          if (wr) begin m_inc[c] = longint'(cfg_inc); m_pv[c] = 0; end
          else if (m_pv[c]) begin m_inc[c] = m_pinc[c]; m_pv[c] = 0; end
        end
        if (wr) m_ph[c] = longint'(cfg_phase);
      end
    end
    #1;
    if (m_valid) begin
      chk("model_locked", locked, m_locked);
      chk("model_ce", ce, m_ce);
      chk("model_cfg_err", cfg_err, m_err);
      chk("model_cfg_ready", cfg_ready, !rst);
    end
  end

  task automatic write(input int ch, input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] ph);
    @(negedge refclk);
    cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_inc = inc; cfg_phase = ph;
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic relock();
    @(negedge refclk);
    locked_in = 1'b1;
    repeat (LOCK_DLY + 4) @(posedge refclk);
    #1 chk("relock_locked", locked, 1);
  endtask

  task automatic unlock();
    @(negedge refclk);
    locked_in = 1'b0;
    repeat (4) @(negedge refclk);
  endtask

  task automatic wait_ce(input int ch, output int en);
    en = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge refclk); #1;
      if (ce[ch]) begin en = edge_n; break; end
    end
    if (en < 0) begin
      tests++; fails++;
      $display("FAIL wait_ce%0d: got no pulse expected one within 200 edges", ch);
    end
  endtask

  initial begin
    int e1, e2, e3, e4, cnt;
    rst = 1'b1; locked_in = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
    repeat (3) @(negedge refclk);
    chk("reset_cfg_ready", cfg_ready, 0);
    chk("reset_locked", locked, 0);
    chk("reset_ce", ce, 0);
    rst = 1'b0;

    // Half-rate channels configured before lock; ch1 carries a half-turn phase.
    write(0, 24'h800000, 24'h000000);
    write(1, 24'h800000, 24'h800000);
    locked_in = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(posedge refclk); #1;
      if (e == 6) chk("locked_before_edge7", locked, 0);
      if (e == 7) chk("locked_at_edge7", locked, 1);
      if (e >= 8) begin
        chk("ce0_run_edge", ce[0], ((e - 8) % 2) == 1);
`ifdef CLKGEN_PHASE_EN
        chk("ce1_leads", ce[1], ((e - 8) % 2) == 0);
`else
        chk("ce1_coincident", ce[1], ((e - 8) % 2) == 1);
`endif
      end
    end

    // Lock loss must clear locked and ce within three edges.
    @(negedge refclk);
    locked_in = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    chk("unlock_locked", locked, 0);
    chk("unlock_ce", ce, 0);

    // Write to a nonexistent channel while running.
    relock();
    @(negedge refclk);
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_inc = 24'h123456;
    @(posedge refclk); #1 chk("cfg_err_pulse", cfg_err, 1);
    @(negedge refclk); cfg_valid = 1'b0;
    @(posedge refclk); #1 chk("cfg_err_single", cfg_err, 0);

    // Glitch-free retune: two writes between carries, latest wins at next carry.
    unlock();
    write(0, 24'h100000, 24'h000000);
    relock();
    wait_ce(0, e1);
    write(0, 24'h400000, 24'h000000);
    write(0, 24'h200000, 24'h000000);
    wait_ce(0, e2);
    wait_ce(0, e3);
    wait_ce(0, e4);
    chk("retune_gap_old", e2 - e1, 16);
    chk("retune_gap_new1", e3 - e2, 8);
    chk("retune_gap_new2", e4 - e3, 8);

    // 6 MHz from 50 MHz: about 120 pulses per 1000 cycles.
    write(1, 24'h1EB852, 24'h000000);
    repeat (40) @(posedge refclk);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge refclk); #1;
      if (ce[1]) cnt++;
    end
    chk("freq_count_in_range", (cnt >= 119) && (cnt <= 121), 1);

    // Reset mid-operation drops pulses and a pending write.
    write(0, 24'h800000, 24'h000000);
    @(negedge refclk); rst = 1'b1;
    @(posedge refclk); #1;
    chk("midreset_locked", locked, 0);
    chk("midreset_ce", ce, 0);
    chk("midreset_ready", cfg_ready, 0);
    @(negedge refclk); rst = 1'b0;
    relock();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge refclk); #1;
      if (ce != '0) cnt++;
    end
    chk("postreset_no_pulses", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/clkgen_frac.md
CLKGEN_FRAC -- requirements
Module: clkgen_frac

Interface
REQ-001 Parameter NUM_CH, default 2: number of clock-enable channels, legal range 1..8.
REQ-002 Parameter ACC_W, default 24: phase-accumulator width, legal range 8..32.
REQ-003 Parameter LOCK_DLY, default 16: RUN entry delay after lock is seen, in cycles; minimum 1.
REQ-004 Parameter INIT_INC, default 0: increment loaded into every channel at reset.
REQ-005 Port refclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 Port locked_in, input, 1 bit: asynchronous PLL lock indication.
REQ-008 Port cfg_valid, input, 1 bit: configuration write request.
REQ-009 Port cfg_ready, output, 1 bit: configuration write can be accepted.
REQ-010 Port cfg_ch, input, 3 bits: target channel index.
REQ-011 Port cfg_inc, input, ACC_W bits: new phase increment.
REQ-012 Port cfg_phase, input, ACC_W bits: phase preload; used only when CLKGEN_PHASE_EN is defined (REQ-032).
REQ-013 Port cfg_err, output, 1 bit: one-cycle pulse flagging a write to a nonexistent channel.
REQ-014 Port ce, output, NUM_CH bits: per-channel one-cycle clock-enable pulses.
REQ-015 Port locked, output, 1 bit: high only in the RUN state.

Function
REQ-016 locked_in SHALL pass through a 2-flop synchroniser; lk_s denotes the synchroniser output.
REQ-017 The state machine SHALL have three states: WAIT_LOCK, SETTLE and RUN.
REQ-018 WAIT_LOCK SHALL go to SETTLE when lk_s=1, clearing the settle counter.
REQ-019 SETTLE SHALL count up each cycle and go to RUN at the edge where the count equals LOCK_DLY-1; lk_s=0 SHALL send it to WAIT_LOCK.
REQ-020 RUN SHALL go to WAIT_LOCK on the first cycle with lk_s=0.
REQ-021 Total latency: locked_in high before edge 1 SHALL give locked=1 after edge 3+LOCK_DLY.
REQ-022 In RUN, each channel SHALL compute acc <= (acc + inc) mod 2^ACC_W at every edge, and ce[ch] SHALL be registered equal to the carry-out of that same sum.
REQ-023 Output frequency SHALL be f_refclk*inc/2^ACC_W; inc=0 SHALL give no pulses; ce is never high two consecutive cycles unless inc >= 2^(ACC_W-1).
REQ-024 Outside RUN, ce SHALL be 0 and every acc SHALL be held at 0 (or at its phase preload, per REQ-032).
REQ-025 cfg_ready SHALL be 1 in every cycle except reset cycles; a write is accepted when cfg_valid && cfg_ready.
REQ-026 An accepted write with cfg_ch >= NUM_CH SHALL change no state and SHALL pulse cfg_err on the next cycle.
REQ-027 Outside RUN, an accepted write SHALL load inc directly; the new value is visible on the next edge.
REQ-028 In RUN, an accepted write SHALL go to a per-channel pending register and is applied at that channel's next carry edge (glitch-free retune).
  - A write on the same edge as a carry waits for the following carry.
  - A channel with current inc=0 applies the write on the next edge.
REQ-029 A second write before the pending value is applied SHALL overwrite it; only the latest value takes effect.
REQ-030 On leaving RUN, any pending value SHALL be applied immediately.

Reset
REQ-031 While rst=1: state=WAIT_LOCK, synchroniser=0, settle counter=0, acc=0, inc=INIT_INC, pending cleared, ce=0, locked=0, cfg_err=0, cfg_ready=0. Reset mid-operation drops all pulses and pending writes at the next edge.

Configuration
REQ-032 With macro CLKGEN_PHASE_EN defined, an accepted write SHALL also set that channel's phase register to cfg_phase, and acc SHALL be preset to it on RUN entry and when a pending value is applied. Without the macro, cfg_phase SHALL be ignored, no phase register is built, and acc restarts from 0.

Verification
REQ-033 ACC_W=24, LOCK_DLY=4; raise locked_in -> locked=1 after edge 7; drop it -> locked=0 and ce=0 within 3 edges.
REQ-034 inc=0x800000 written before lock -> ce pulses on the 2nd, 4th, 6th RUN edge.
REQ-035 inc=0x1EB852 (6 MHz from 50 MHz) -> exactly 120 ce pulses (±1) in 1000 RUN cycles.
REQ-036 In RUN, write inc=0x400000 then 0x200000 before a carry -> period changes only after the next carry, to 8 cycles; no shortened pulse gap.
REQ-037 NUM_CH=2, write cfg_ch=5 -> cfg_err pulses for 1 cycle; ce pattern unchanged.
REQ-038 With CLKGEN_PHASE_EN: ch0 and ch1 both inc=0x800000, ch1 phase=0x800000 -> ce[1] leads ce[0] by 1 cycle; without the macro both are coincident.
